// File: rtl/pstore_sequencer.sv
// pstore_sequencer: runs one layer-1 accumulation on pStore (clear, bias load, NUM_INPUTS weight fetches).
// Optional abort input is compiled in when PSEQ_ABORT_EN is defined.

`ifndef RELU_NODES
`define RELU_NODES 1
`endif
`ifndef LAYER_1_BIT_WIDTH
`define LAYER_1_BIT_WIDTH 8
`endif

module pstore_sequencer #(
    parameter int NUM_INPUTS = 784,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                                        clk,
    input  logic                                        clr_n,
    input  logic                                        start,
`ifdef PSEQ_ABORT_EN
    input  logic                                        abort,
`endif
    output logic                                        busy,
    output logic                                        done,
    output logic                                        result_valid,
    input  logic                                        result_ack,
    output logic                                        wmem_req,
    output logic [ADDR_WIDTH-1:0]                       wmem_addr,
    input  logic                                        wmem_ack,
    input  logic [`RELU_NODES*`LAYER_1_BIT_WIDTH-1:0]   wmem_data,
    input  logic [`RELU_NODES*`LAYER_1_BIT_WIDTH-1:0]   bias_data,
    output logic                                        ps_clr,
    output logic                                        ps_bias_we,
    output logic [`RELU_NODES*`LAYER_1_BIT_WIDTH-1:0]   ps_weights,
    output logic [`RELU_NODES*`LAYER_1_BIT_WIDTH-1:0]   ps_biases
);

    localparam int DW    = `RELU_NODES*`LAYER_1_BIT_WIDTH;
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_BIAS   = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_ACC    = 3'd4;
    localparam logic [2:0] S_SETTLE = 3'd5;
    localparam logic [2:0] S_HOLD   = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic                  busy_q, done_q, result_valid_q, wmem_req_q;
    logic                  ps_clr_q, ps_bias_we_q;
    logic [ADDR_WIDTH-1:0] wmem_addr_q;
    logic [DW-1:0]         ps_weights_q, ps_biases_q;
    logic                  abort_req;

`ifdef PSEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Next-state logic; an ack only counts while our request is actually up.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_BIAS;
            S_BIAS:   state_d = S_FETCH;
            S_FETCH:  if (wmem_req_q && wmem_ack) state_d = S_ACC;
            S_ACC: begin
                if (index_q == LAST_IDX) begin
                    state_d = S_SETTLE;
                end else begin
                    index_d = index_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_SETTLE: state_d = S_HOLD;
            S_HOLD:   if (result_ack) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort_req && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
        if (state_d == S_IDLE) begin
            index_d = '0;
        end
    end

    // Every output is registered straight from the next state so pStore sees clean levels.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q        <= S_IDLE;
            index_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            wmem_req_q     <= 1'b0;
            wmem_addr_q    <= ADDR_WIDTH'(BASE_ADDR);
            ps_clr_q       <= 1'b1;
            ps_bias_we_q   <= 1'b0;
            ps_weights_q   <= '0;
            ps_biases_q    <= '0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            busy_q         <= (state_d != S_IDLE);
            done_q         <= (state_d == S_HOLD) && (state_q != S_HOLD);
            result_valid_q <= (state_d == S_HOLD);
            wmem_req_q     <= (state_d == S_FETCH);
            wmem_addr_q    <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(index_d);
            ps_clr_q       <= (state_d == S_IDLE) || (state_d == S_CLEAR);
            ps_bias_we_q   <= (state_d == S_BIAS);
            ps_biases_q    <= (state_d == S_BIAS) ? bias_data : '0;
            ps_weights_q   <= (state_d == S_ACC) ? wmem_data : '0;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign wmem_req     = wmem_req_q;
    assign wmem_addr    = wmem_addr_q;
    assign ps_clr       = ps_clr_q;
    assign ps_bias_we   = ps_bias_we_q;
    assign ps_weights   = ps_weights_q;
    assign ps_biases    = ps_biases_q;

endmodule

// File: tb/tb_pstore_sequencer.sv
// Testbench for pstore_sequencer: per-cycle expected output timelines built from the run rules,
// two instances (NUM_INPUTS=2 and NUM_INPUTS=1); abort scenario compiled in with PSEQ_ABORT_EN.

`ifndef RELU_NODES
`define RELU_NODES 1
`endif
`ifndef LAYER_1_BIT_WIDTH
`define LAYER_1_BIT_WIDTH 8
`endif

module tb_pstore_sequencer;

    localparam int DW  = `RELU_NODES*`LAYER_1_BIT_WIDTH;
    localparam int CW  = 14 + 2*DW;
    localparam int NA  = 2;
    localparam int BA  = 5;
    localparam int AWA = 4;
    localparam int NB  = 1;
    localparam int BB  = 3;
    localparam int AWB = 3;

    localparam int K_IDLE = 0, K_CLEAR = 1, K_BIAS = 2, K_FETCH = 3;
    localparam int K_ACC = 4, K_SETTLE = 5, K_HOLD = 6, K_HOLDFIRST = 7;

    typedef struct {
        logic          start, wack, rack, abort;
        logic [DW-1:0] wdata, bias;
        logic          busy, done, rv, req, clr, bwe;
        logic [7:0]    addr;
        logic [DW-1:0] wts, bis;
        logic          sumCheck;
        logic [DW-1:0] sumExp;
    } vec_t;

    logic clk = 1'b0;
    logic clr_n;

    logic           aStart, aWack, aRack, aBusy, aDone, aRv, aReq, aClr, aBwe;
    logic [DW-1:0]  aWdata, aBias, aWts, aBis, aAcc;
    logic [AWA-1:0] aAddr;
    logic           bStart, bWack, bRack, bBusy, bDone, bRv, bReq, bClr, bBwe;
    logic [DW-1:0]  bWdata, bBias, bWts, bBis, bAcc;
    logic [AWB-1:0] bAddr;
`ifdef PSEQ_ABORT_EN
    logic           aAbort, bAbort;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t runQ[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    pstore_sequencer #(.NUM_INPUTS(NA), .ADDR_WIDTH(AWA), .BASE_ADDR(BA)) dutA (
        .clk(clk), .clr_n(clr_n), .start(aStart),
`ifdef PSEQ_ABORT_EN
        .abort(aAbort),
`endif
        .busy(aBusy), .done(aDone), .result_valid(aRv), .result_ack(aRack),
        .wmem_req(aReq), .wmem_addr(aAddr), .wmem_ack(aWack), .wmem_data(aWdata),
        .bias_data(aBias), .ps_clr(aClr), .ps_bias_we(aBwe),
        .ps_weights(aWts), .ps_biases(aBis)
    );

    pstore_sequencer #(.NUM_INPUTS(NB), .ADDR_WIDTH(AWB), .BASE_ADDR(BB)) dutB (
        .clk(clk), .clr_n(clr_n), .start(bStart),
`ifdef PSEQ_ABORT_EN
        .abort(bAbort),
`endif
        .busy(bBusy), .done(bDone), .result_valid(bRv), .result_ack(bRack),
        .wmem_req(bReq), .wmem_addr(bAddr), .wmem_ack(bWack), .wmem_data(bWdata),
        .bias_data(bBias), .ps_clr(bClr), .ps_bias_we(bBwe),
        .ps_weights(bWts), .ps_biases(bBis)
    );

    // Stand-in for pStore: clear, load bias, otherwise add the presented word every clock.
    always @(posedge clk) begin
        if (aClr) aAcc <= '0; else if (aBwe) aAcc <= aBis; else aAcc <= aAcc + aWts;
        if (bClr) bAcc <= '0; else if (bBwe) bAcc <= bBis; else bAcc <= bAcc + bWts;
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [DW-1:0] rd();
        return DW'($urandom);
    endfunction

    function automatic vec_t mkVec(int kind, logic st, logic wack, logic [DW-1:0] wdata, logic rack,
                                   logic [DW-1:0] bias, int addr, logic [DW-1:0] d);
        vec_t v;
        v.start = st; v.wack = wack; v.wdata = wdata; v.rack = rack; v.abort = 1'b0; v.bias = bias;
        v.busy = (kind != K_IDLE);
        v.done = (kind == K_HOLDFIRST);
        v.rv   = (kind == K_HOLD) || (kind == K_HOLDFIRST);
        v.req  = (kind == K_FETCH);
        v.clr  = (kind == K_IDLE) || (kind == K_CLEAR);
        v.bwe  = (kind == K_BIAS);
        v.addr = 8'(addr);
        v.wts  = (kind == K_ACC) ? d : '0;
        v.bis  = (kind == K_BIAS) ? bias : '0;
        v.sumCheck = 1'b0;
        v.sumExp   = '0;
        return v;
    endfunction

    function automatic vec_t getAct(int sel);
        vec_t v;
        v = mkVec(K_IDLE, 1'b0, 1'b0, '0, 1'b0, '0, 0, '0);
        if (sel == 0) begin
            v.busy = aBusy; v.done = aDone; v.rv = aRv; v.req = aReq; v.clr = aClr; v.bwe = aBwe;
            v.addr = 8'(aAddr); v.wts = aWts; v.bis = aBis;
        end else begin
            v.busy = bBusy; v.done = bDone; v.rv = bRv; v.req = bReq; v.clr = bClr; v.bwe = bBwe;
            v.addr = 8'(bAddr); v.wts = bWts; v.bis = bBis;
        end
        return v;
    endfunction

    function automatic logic [CW-1:0] packOut(vec_t v, logic keepAddr, logic keepBis);
        return {v.busy, v.done, v.rv, v.req, v.clr, v.bwe, keepAddr ? v.addr : 8'h00,
                v.wts, keepBis ? v.bis : {DW{1'b0}}};
    endfunction

    task automatic checkOutput(input int sel, input vec_t e, input string tag, input int idx);
        vec_t          a;
        logic [DW-1:0] acc;
        a = getAct(sel);
        checks++;
        if (packOut(a, e.req, e.bwe) !== packOut(e, e.req, e.bwe)) begin
            errors++;
            $display("[TB] FAIL %s[%0d] outputs got %h want %h (busy,done,rv,req,clr,bwe,addr,wts,bis)",
                     tag, idx, packOut(a, e.req, e.bwe), packOut(e, e.req, e.bwe));
        end
        if (e.sumCheck) begin
            acc = (sel == 0) ? aAcc : bAcc;
            checks++;
            if (acc !== e.sumExp) begin
                errors++;
                $display("[TB] FAIL %s[%0d] pStore sum got %h want %h", tag, idx, acc, e.sumExp);
            end
        end
    endtask

    task automatic checkReset(input int sel, input string tag);
        vec_t a, r;
        a = getAct(sel);
        r = mkVec(K_IDLE, 1'b0, 1'b0, '0, 1'b0, '0, (sel == 0) ? BA : BB, '0);
        checks++;
        if (packOut(a, 1'b1, 1'b1) !== packOut(r, 1'b1, 1'b1)) begin
            errors++;
            $display("[TB] FAIL %s reset outputs got %h want %h", tag, packOut(a, 1'b1, 1'b1),
                     packOut(r, 1'b1, 1'b1));
        end
    endtask

    task automatic applyStimulus(input int sel, input vec_t v, input string tag, input int idx);
        aStart = 1'b0; aWack = 1'b0; aWdata = '0; aRack = 1'b0; aBias = '0;
        bStart = 1'b0; bWack = 1'b0; bWdata = '0; bRack = 1'b0; bBias = '0;
`ifdef PSEQ_ABORT_EN
        aAbort = 1'b0; bAbort = 1'b0;
        if (sel == 0) aAbort = v.abort; else bAbort = v.abort;
`endif
        if (sel == 0) begin
            aStart = v.start; aWack = v.wack; aWdata = v.wdata; aRack = v.rack; aBias = v.bias;
        end else begin
            bStart = v.start; bWack = v.wack; bWdata = v.wdata; bRack = v.rack; bBias = v.bias;
        end
        @(posedge clk);
        #1;
        checkOutput(sel, v, tag, idx);
    endtask

    // Builds the cycle-by-cycle expectation of one run; mode 1 = fixed 8'hFA/5A/F9 data, mode 2 = word 8'h01.
    task automatic buildRun(input int sel, input int mode, input int fixedWait, input int maxWait,
                            input int holdWait, input bit startInHold);
        int            n, base, w;
        logic [DW-1:0] bias, word, sum;
        vec_t          v;
        n    = (sel == 0) ? NA : NB;
        base = (sel == 0) ? BA : BB;
        bias = (mode == 1) ? DW'(8'hFA) : rd();
        sum  = bias;
        runQ.push_back(mkVec(K_CLEAR, 1'b1, rb(), rd(), rb(), bias, base, '0));
        runQ.push_back(mkVec(K_BIAS, rb(), rb(), rd(), rb(), bias, base, '0));
        for (int i = 0; i < n; i++) begin
            if (mode == 1)      word = (i == 0) ? DW'(8'h5A) : DW'(8'hF9);
            else if (mode == 2) word = DW'(1);
            else                word = rd();
            sum = sum + word;
            w = (fixedWait >= 0) ? fixedWait : $urandom_range(0, maxWait);
            runQ.push_back(mkVec(K_FETCH, rb(), rb(), rd(), rb(), bias, base + i, '0));
            for (int j = 0; j < w; j++)
                runQ.push_back(mkVec(K_FETCH, rb(), 1'b0, rd(), rb(), bias, base + i, '0));
            runQ.push_back(mkVec(K_ACC, rb(), 1'b1, word, rb(), bias, base + i, word));
        end
        runQ.push_back(mkVec(K_SETTLE, rb(), rb(), rd(), rb(), bias, base, '0));
        v = mkVec(K_HOLDFIRST, rb(), rb(), rd(), rb(), bias, base, '0);
        v.sumCheck = 1'b1;
        v.sumExp   = sum;
        runQ.push_back(v);
        for (int j = 0; j < holdWait; j++)
            runQ.push_back(mkVec(K_HOLD, startInHold ? 1'b1 : rb(), rb(), rd(), 1'b0, bias, base, '0));
        runQ.push_back(mkVec(K_IDLE, startInHold ? 1'b1 : rb(), rb(), rd(), 1'b1, bias, base, '0));
        runQ.push_back(mkVec(K_IDLE, 1'b0, rb(), rd(), rb(), bias, base, '0));
    endtask

    task automatic playRun(input int sel, input string tag);
        foreach (runQ[i]) applyStimulus(sel, runQ[i], tag, i);
        runQ.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout reached before the test sequence finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t v;
        tbl[0] = mkVec(K_CLEAR,     1'b1, 1'b0, '0,         1'b0, DW'(8'hFA), BA,     '0);
        tbl[1] = mkVec(K_BIAS,      1'b0, 1'b0, '0,         1'b0, DW'(8'hFA), BA,     '0);
        tbl[2] = mkVec(K_FETCH,     1'b0, 1'b0, '0,         1'b0, DW'(8'hFA), BA,     '0);
        tbl[3] = mkVec(K_ACC,       1'b0, 1'b1, DW'(8'h5A), 1'b0, DW'(8'hFA), BA,     DW'(8'h5A));
        tbl[4] = mkVec(K_FETCH,     1'b0, 1'b0, '0,         1'b0, DW'(8'hFA), BA + 1, '0);
        tbl[5] = mkVec(K_ACC,       1'b0, 1'b1, DW'(8'hF9), 1'b0, DW'(8'hFA), BA + 1, DW'(8'hF9));
        tbl[6] = mkVec(K_SETTLE,    1'b0, 1'b0, '0,         1'b0, DW'(8'hFA), BA,     '0);
        tbl[7] = mkVec(K_HOLDFIRST, 1'b0, 1'b0, '0,         1'b0, DW'(8'hFA), BA,     '0);
        tbl[7].sumCheck = 1'b1;
        tbl[7].sumExp   = DW'(8'h4D);
        tbl[8] = mkVec(K_IDLE,      1'b0, 1'b0, '0,         1'b1, DW'(8'hFA), BA,     '0);

        aStart = 1'b0; aWack = 1'b0; aWdata = '0; aRack = 1'b0; aBias = '0;
        bStart = 1'b0; bWack = 1'b0; bWdata = '0; bRack = 1'b0; bBias = '0;
`ifdef PSEQ_ABORT_EN
        aAbort = 1'b0; bAbort = 1'b0;
`endif
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        checkReset(0, "resetA");
        checkReset(1, "resetB");
        @(negedge clk);
        clr_n = 1'b1;

        $display("[TB] scenario 1: zero-wait two-word run");
        for (int i = 0; i < 9; i++) applyStimulus(0, tbl[i], "s1", i);

        $display("[TB] scenario 2: three wait cycles per word");
        buildRun(0, 1, 3, 0, 0, 1'b0);
        playRun(0, "s2");

        $display("[TB] scenario 3: result_ack held off, start during HOLD");
        buildRun(0, 0, -1, 2, 10, 1'b1);
        playRun(0, "s3");

        $display("[TB] scenario 4: reset during second FETCH");
        for (int i = 0; i < 5; i++) applyStimulus(0, tbl[i], "s4", i);
        #2;
        clr_n = 1'b0;
        #1;
        checkReset(0, "s4async");
        @(posedge clk);
        #1;
        checkReset(0, "s4held");
        @(negedge clk);
        clr_n = 1'b1;
        applyStimulus(0, mkVec(K_IDLE, 1'b0, 1'b1, DW'(8'h77), 1'b0, '0, BA, '0), "s4lateack", 0);
        buildRun(0, 0, -1, 2, 1, 1'b0);
        playRun(0, "s4rerun");

        $display("[TB] scenario 5: single-word instance");
        buildRun(1, 2, 0, 0, 0, 1'b0);
        checks++;
        if (runQ[5].done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL s5 timeline done index got %0b want 1", runQ[5].done);
        end
        playRun(1, "s5");

`ifdef PSEQ_ABORT_EN
        $display("[TB] scenario 6: abort during ACC");
        for (int i = 0; i < 4; i++) applyStimulus(0, tbl[i], "s6", i);
        v = mkVec(K_IDLE, 1'b0, 1'b0, '0, 1'b0, DW'(8'hFA), BA, '0);
        v.abort = 1'b1;
        applyStimulus(0, v, "s6abort", 0);
        applyStimulus(0, mkVec(K_IDLE, 1'b0, 1'b1, DW'(8'h33), 1'b0, '0, BA, '0), "s6lateack", 0);
        applyStimulus(0, mkVec(K_IDLE, 1'b0, 1'b0, '0, 1'b1, '0, BA, '0), "s6idle", 0);
        v = mkVec(K_CLEAR, 1'b1, 1'b0, '0, 1'b0, DW'(8'hFA), BA, '0);
        v.abort = 1'b1;
        applyStimulus(0, v, "s6startwins", 0);
        v = mkVec(K_IDLE, 1'b0, 1'b0, '0, 1'b0, DW'(8'hFA), BA, '0);
        v.abort = 1'b1;
        applyStimulus(0, v, "s6abortclear", 0);
        buildRun(0, 0, -1, 2, 1, 1'b0);
        playRun(0, "s6rerun");
`else
        v = mkVec(K_IDLE, 1'b0, 1'b0, '0, 1'b0, '0, BA, '0);
        applyStimulus(0, v, "idlegap", 0);
`endif

        $display("[TB] randomized runs");
        for (int r = 0; r < 24; r++) begin
            int sel;
            sel = $urandom_range(0, 1);
            buildRun(sel, 0, -1, 3, $urandom_range(0, 4), 1'b0);
            playRun(sel, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
